// File: rtl/hdmi_pattern_sequencer.sv
// hdmi_pattern_sequencer: Wishbone-programmed scheduler that applies test-pattern changes on frame boundaries.
// Optional interrupt support is compiled in by defining HDMI_PATTERN_SEQ_IRQ_EN.
module hdmi_pattern_sequencer #(
    parameter int NUM_PATTERNS = 8,
    parameter int PAT_W        = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       wb_adr_i,
    input  logic [7:0]       wb_dat_i,
    output logic [7:0]       wb_dat_o,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    output logic             wb_ack_o,
    input  logic             vsync_i,
    output logic [PAT_W-1:0] pattern_sel_o,
    output logic             pattern_en_o,
    output logic             frame_irq_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam logic [7:0] ADR_CTRL    = 8'h10;
    localparam logic [7:0] ADR_PATTERN = 8'h11;
    localparam logic [7:0] ADR_DWELL   = 8'h12;
    localparam logic [7:0] ADR_LAST    = 8'h13;
    localparam logic [7:0] ADR_STATUS  = 8'h14;
    localparam logic [7:0] ADR_FCNT    = 8'h15;

    localparam logic [7:0] LAST_MAX  = 8'(NUM_PATTERNS - 1);
    localparam logic [7:0] DWELL_RST = 8'h3C;

    // A dwell of zero frames is meaningless, so it behaves as one.
    function automatic logic [7:0] dwell_eff(input logic [7:0] v);
        if (v == 8'd0) begin
            dwell_eff = 8'd1;
        end else begin
            dwell_eff = v;
        end
    endfunction

    function automatic logic [7:0] clamp_last(input logic [7:0] v);
        if (v > LAST_MAX) begin
            clamp_last = LAST_MAX;
        end else begin
            clamp_last = v;
        end
    endfunction

    function automatic logic [PAT_W-1:0] to_pat(input logic [7:0] v);
        if (v > LAST_MAX) begin
            to_pat = LAST_MAX[PAT_W-1:0];
        end else begin
            to_pat = v[PAT_W-1:0];
        end
    endfunction

    // Any index at or beyond LAST (including one set by hand) wraps to 0.
    function automatic logic [PAT_W-1:0] next_pat(input logic [PAT_W-1:0] cur, input logic [7:0] last);
        if ({{(8-PAT_W){1'b0}}, cur} >= last) begin
            next_pat = '0;
        end else begin
            next_pat = cur + PAT_W'(1);
        end
    endfunction

    logic [SYNC_STAGES-1:0] vs_sync_r;
    logic                   vs_prev_r;
    logic                   tick_r;

    logic                   ack_r;
    logic [7:0]             dat_r;
    logic                   req_s;
    logic                   wr_s;
    logic                   rd_s;
    logic [7:0]             rdata_s;

    logic                   ctrl_en_r;
    logic                   ctrl_run_r;
    logic [7:0]             dwell_r;
    logic [7:0]             last_r;
    logic [PAT_W-1:0]       pend_pat_r;
    logic                   pend_valid_r;

    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [PAT_W-1:0]       sel_r;
    logic [PAT_W-1:0]       sel_nxt_s;
    logic                   en_r;
    logic                   en_nxt_s;
    logic [7:0]             dwell_cnt_r;
    logic [7:0]             dwell_nxt_s;
    logic                   pat_apply_s;
    logic                   advance_s;
    logic [15:0]            frame_cnt_r;
    logic                   frame_cnt_hi_unused_s;

    logic                   irq_en_rd_s;
    logic                   irq_pend_rd_s;

    assign req_s = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s  = req_s & wb_we_i;
    assign rd_s  = req_s & ~wb_we_i;

    assign wb_ack_o      = ack_r;
    assign wb_dat_o      = dat_r;
    assign pattern_sel_o = sel_r;
    assign pattern_en_o  = en_r;
    assign frame_cnt_hi_unused_s = ^frame_cnt_r[15:8];

    // vsync synchronizer and rising-edge detector producing a registered one-cycle frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_r <= '0;
            vs_prev_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            vs_sync_r <= {vs_sync_r[SYNC_STAGES-2:0], vsync_i};
            vs_prev_r <= vs_sync_r[SYNC_STAGES-1];
            tick_r    <= vs_sync_r[SYNC_STAGES-1] & ~vs_prev_r;
        end
    end

    // Register read multiplexer.
    always_comb begin
        rdata_s = 8'h00;
        case (wb_adr_i)
            ADR_CTRL:    rdata_s = {5'b00000, irq_en_rd_s, ctrl_run_r, ctrl_en_r};
            ADR_PATTERN: rdata_s = {{(8-PAT_W){1'b0}}, sel_r};
            ADR_DWELL:   rdata_s = dwell_r;
            ADR_LAST:    rdata_s = last_r;
            ADR_STATUS:  rdata_s = {6'b000000, (state_r == ST_RUN), irq_pend_rd_s};
            ADR_FCNT:    rdata_s = frame_cnt_r[7:0];
            default:     rdata_s = 8'h00;
        endcase
    end

    // Wishbone acknowledge pulse and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            dat_r <= 8'h00;
        end else begin
            ack_r <= req_s;
            if (rd_s) begin
                dat_r <= rdata_s;
            end else begin
                dat_r <= 8'h00;
            end
        end
    end

    // Configuration and shadow registers; a new PATTERN write beats a same-cycle apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_r    <= 1'b1;
            ctrl_run_r   <= 1'b0;
            dwell_r      <= DWELL_RST;
            last_r       <= LAST_MAX;
            pend_pat_r   <= '0;
            pend_valid_r <= 1'b0;
        end else begin
            if (wr_s && (wb_adr_i == ADR_CTRL)) begin
                ctrl_en_r  <= wb_dat_i[0];
                ctrl_run_r <= wb_dat_i[1];
            end
            if (wr_s && (wb_adr_i == ADR_DWELL)) begin
                dwell_r <= wb_dat_i;
            end
            if (wr_s && (wb_adr_i == ADR_LAST)) begin
                last_r <= clamp_last(wb_dat_i);
            end
            if (wr_s && (wb_adr_i == ADR_PATTERN)) begin
                pend_pat_r   <= to_pat(wb_dat_i);
                pend_valid_r <= 1'b1;
            end else if (pat_apply_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    // Sequencer next-state logic; everything visible moves only on a frame tick.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        en_nxt_s    = en_r;
        dwell_nxt_s = dwell_cnt_r;
        pat_apply_s = 1'b0;
        advance_s   = 1'b0;
        if (tick_r) begin
            en_nxt_s = ctrl_en_r;
            case (state_r)
                ST_IDLE, ST_MANUAL: begin
                    if (pend_valid_r) begin
                        sel_nxt_s   = pend_pat_r;
                        pat_apply_s = 1'b1;
                    end else begin
                        sel_nxt_s = sel_r;
                    end
                    if (ctrl_run_r) begin
                        state_nxt_s = ST_RUN;
                        dwell_nxt_s = dwell_eff(dwell_r);
                    end else begin
                        state_nxt_s = ST_MANUAL;
                    end
                end
                ST_RUN: begin
                    if (!ctrl_run_r) begin
                        state_nxt_s = ST_MANUAL;
                    end else if (pend_valid_r) begin
                        sel_nxt_s   = pend_pat_r;
                        pat_apply_s = 1'b1;
                        dwell_nxt_s = dwell_eff(dwell_r);
                    end else if (dwell_cnt_r <= 8'd1) begin
                        sel_nxt_s   = next_pat(sel_r, last_r);
                        advance_s   = 1'b1;
                        dwell_nxt_s = dwell_eff(dwell_r);
                    end else begin
                        dwell_nxt_s = dwell_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Sequencer state, active outputs and free-running frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= '0;
            en_r        <= 1'b1;
            dwell_cnt_r <= 8'd0;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            sel_r       <= sel_nxt_s;
            en_r        <= en_nxt_s;
            dwell_cnt_r <= dwell_nxt_s;
            if (tick_r) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

`ifdef HDMI_PATTERN_SEQ_IRQ_EN
    logic ctrl_irq_en_r;
    logic irq_pend_r;
    logic irq_r;
    logic irq_pend_nxt_s;
    logic irq_en_nxt_s;

    // Pending-interrupt next value: a same-cycle set wins over a write-1 clear.
    always_comb begin
        irq_pend_nxt_s = irq_pend_r;
        if (pat_apply_s || advance_s) begin
            irq_pend_nxt_s = 1'b1;
        end else if (wr_s && (wb_adr_i == ADR_STATUS) && wb_dat_i[0]) begin
            irq_pend_nxt_s = 1'b0;
        end else begin
            irq_pend_nxt_s = irq_pend_r;
        end
        if (wr_s && (wb_adr_i == ADR_CTRL)) begin
            irq_en_nxt_s = wb_dat_i[2];
        end else begin
            irq_en_nxt_s = ctrl_irq_en_r;
        end
    end

    // Interrupt state; the output is registered from next-state so it tracks PEND & EN without lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_irq_en_r <= 1'b0;
            irq_pend_r    <= 1'b0;
            irq_r         <= 1'b0;
        end else begin
            ctrl_irq_en_r <= irq_en_nxt_s;
            irq_pend_r    <= irq_pend_nxt_s;
            irq_r         <= irq_pend_nxt_s & irq_en_nxt_s;
        end
    end

    assign irq_en_rd_s   = ctrl_irq_en_r;
    assign irq_pend_rd_s = irq_pend_r;
    assign frame_irq_o   = irq_r;
`else
    assign irq_en_rd_s   = 1'b0;
    assign irq_pend_rd_s = 1'b0;
    assign frame_irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_pattern_sequencer.sv
// Scoreboard bench for hdmi_pattern_sequencer: stimulus queues expectations, monitors pop and compare.
`timescale 1ns/1ps
module tb_hdmi_pattern_sequencer;

`ifdef HDMI_PATTERN_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wb_adr_i = 8'h00;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_cyc_i = 1'b0;
    logic       wb_stb_i = 1'b0;
    logic       wb_we_i = 1'b0;
    logic       wb_ack_o;
    logic       vsync_i = 1'b0;
    logic [2:0] pattern_sel_o;
    logic       pattern_en_o;
    logic       frame_irq_o;

    hdmi_pattern_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_we_i      (wb_we_i),
        .wb_ack_o     (wb_ack_o),
        .vsync_i      (vsync_i),
        .pattern_sel_o(pattern_sel_o),
        .pattern_en_o (pattern_en_o),
        .frame_irq_o  (frame_irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_read;
        logic [7:0] data;
        string      tag;
    } bus_exp_t;

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic       irq;
        logic       bus_idle;
        string      tag;
    } out_exp_t;

    bus_exp_t bus_q[$];
    out_exp_t out_q[$];
    int       n_test = 0;
    int       n_fail = 0;
    int       frames = 0;
    logic     sample_req = 1'b0;
    logic     snap_req = 1'b0;
    logic     ack_prev = 1'b0;
    logic [2:0] run_seq [10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};

    // Bus monitor: every ack consumes one queued access; reads are checked against the queued data.
    always @(negedge clk) begin
        bus_exp_t be;
        if (wb_ack_o) begin
            n_test++;
            if (ack_prev) begin
                n_fail++;
                $display("FAIL ack_width: ack high on consecutive cycles, required a single-cycle pulse");
            end else if (bus_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected: ack=1 with no access outstanding");
            end else begin
                be = bus_q.pop_front();
                if (be.is_read && (wb_dat_o !== be.data)) begin
                    n_fail++;
                    $display("FAIL %s: read 0x%02h, required 0x%02h", be.tag, wb_dat_o, be.data);
                end
            end
        end
        ack_prev = wb_ack_o;
    end

    // Output monitor: compares the pattern outputs whenever the stimulus presents a sample point.
    always @(negedge clk or posedge snap_req) begin
        out_exp_t oe;
        if (sample_req || snap_req) begin
            n_test++;
            if (out_q.size() == 0) begin
                n_fail++;
                $display("FAIL sample_underflow: sample point with no expectation queued");
            end else begin
                oe = out_q.pop_front();
                if ((pattern_sel_o !== oe.sel) || (pattern_en_o !== oe.en) || (frame_irq_o !== oe.irq) ||
                    (oe.bus_idle && ((wb_ack_o !== 1'b0) || (wb_dat_o !== 8'h00)))) begin
                    n_fail++;
                    $display("FAIL %s: sel=%0d en=%0b irq=%0b ack=%0b dat=0x%02h, required sel=%0d en=%0b irq=%0b",
                             oe.tag, pattern_sel_o, pattern_en_o, frame_irq_o, wb_ack_o, wb_dat_o,
                             oe.sel, oe.en, oe.irq);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                           input logic [7:0] exp, input string tag);
        bus_exp_t be;
        bit seen;
        be.is_read = !we;
        be.data    = exp;
        be.tag     = tag;
        bus_q.push_back(be);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (wb_ack_o) seen = 1'b1;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!seen) begin
            n_test++;
            n_fail++;
            $display("FAIL %s: no ack within 4 cycles at adr 0x%02h, required ack", tag, adr);
            bus_q.delete();
        end
        step();
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [7:0] dat);
        wb_xfer(1'b1, adr, dat, 8'h00, "wr");
    endtask

    task automatic wb_rd(input logic [7:0] adr, input logic [7:0] exp, input string tag);
        wb_xfer(1'b0, adr, 8'h00, exp, tag);
    endtask

    task automatic sample(input logic [2:0] sel, input logic en, input logic irq, input string tag);
        out_exp_t oe;
        oe.sel = sel; oe.en = en; oe.irq = irq; oe.bus_idle = 1'b0; oe.tag = tag;
        out_q.push_back(oe);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
    endtask

    task automatic frame();
        vsync_i = 1'b1;
        repeat (8) step();
        vsync_i = 1'b0;
        repeat (4) step();
        frames++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        frames = 0;
    endtask

    initial begin
        out_exp_t oe;
        // Reset values, including the bus outputs.
        repeat (2) step();
        oe.sel = 3'd0; oe.en = 1'b1; oe.irq = 1'b0; oe.bus_idle = 1'b1; oe.tag = "reset_out";
        out_q.push_back(oe);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        rst_n = 1'b1;
        step();

        wb_rd(8'h10, 8'h01, "rst_ctrl");
        wb_rd(8'h12, 8'h3C, "rst_dwell");
        wb_rd(8'h13, 8'h07, "rst_last");
        wb_rd(8'h14, 8'h00, "rst_status");
        wb_rd(8'h15, 8'h00, "rst_fcnt");
        wb_wr(8'h20, 8'hFF);
        wb_rd(8'h20, 8'h00, "unmapped_rd");
        wb_rd(8'h10, 8'h01, "unmapped_wr_ignored");

        // Shadowed PATTERN write with exact boundary latency.
        wb_wr(8'h11, 8'h05);
        wb_rd(8'h11, 8'h00, "pat_before_tick");
        vsync_i = 1'b1;
        repeat (3) step();
        sample(3'd0, 1'b1, 1'b0, "pat_hold_at_tick");
        sample(3'd5, 1'b1, 1'b0, "pat_applied");
        repeat (3) step();
        vsync_i = 1'b0;
        repeat (4) step();
        frames++;
        wb_rd(8'h11, 8'h05, "pat_readback");
        wb_rd(8'h15, 8'(frames), "fcnt_one");

        // Auto-advance with DWELL=2, LAST=3.
        do_reset();
        wb_wr(8'h12, 8'h02);
        wb_wr(8'h13, 8'h03);
        wb_wr(8'h10, 8'h03);
        for (int i = 0; i < 10; i++) begin
            frame();
            sample(run_seq[i], 1'b1, 1'b0, $sformatf("run_seq%0d", i));
        end
        wb_rd(8'h14, {7'b0000001, IRQ_ON}, "status_running");
        wb_rd(8'h15, 8'(frames), "fcnt_ten");

        // Asynchronous reset in the middle of a dwell at pattern 2.
        do_reset();
        wb_wr(8'h12, 8'h02);
        wb_wr(8'h13, 8'h03);
        wb_wr(8'h10, 8'h03);
        repeat (5) frame();
        sample(3'd2, 1'b1, 1'b0, "pre_async_rst");
        #1;
        rst_n = 1'b0;
        #1;
        oe.sel = 3'd0; oe.en = 1'b1; oe.irq = 1'b0; oe.bus_idle = 1'b1; oe.tag = "async_rst";
        out_q.push_back(oe);
        snap_req = 1'b1;
        #1;
        snap_req = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        frames = 0;
        wb_rd(8'h15, 8'h00, "post_rst_fcnt");
        wb_rd(8'h14, 8'h00, "post_rst_idle");
        wb_rd(8'h10, 8'h01, "post_rst_ctrl");

        // DWELL=0 advances every frame; LAST clamps.
        wb_wr(8'h12, 8'h00);
        wb_wr(8'h13, 8'h20);
        wb_rd(8'h13, 8'h07, "last_clamp");
        wb_rd(8'h12, 8'h00, "dwell_zero_rd");
        wb_wr(8'h10, 8'h03);
        for (int i = 0; i < 4; i++) begin
            frame();
            sample(3'(i), 1'b1, 1'b0, $sformatf("dwell0_%0d", i));
        end
        wb_wr(8'h10, 8'h01);
        frame();
        sample(3'd3, 1'b1, 1'b0, "run_clear_hold");
        wb_wr(8'h13, 8'h02);
        wb_wr(8'h11, 8'h06);
        frame();
        sample(3'd6, 1'b1, 1'b0, "manual_apply");
        wb_wr(8'h10, 8'h03);
        frame();
        sample(3'd6, 1'b1, 1'b0, "enter_run");
        frame();
        sample(3'd0, 1'b1, 1'b0, "above_last_wrap");
        frame();
        sample(3'd1, 1'b1, 1'b0, "after_wrap");
        wb_wr(8'h10, 8'h02);
        sample(3'd1, 1'b1, 1'b0, "en_shadow_hold");
        frame();
        sample(3'd2, 1'b0, 1'b0, "en_shadow_apply");

        // Interrupt: set on advance, set beats a same-cycle clear, clear alone drops it.
        wb_wr(8'h14, 8'h01);
        wb_wr(8'h10, 8'h07);
        sample(3'd2, 1'b0, 1'b0, "irq_idle");
        frame();
        sample(3'd0, 1'b1, IRQ_ON, "irq_set");
        vsync_i = 1'b1;
        repeat (3) step();
        wb_wr(8'h14, 8'h01);
        repeat (4) step();
        vsync_i = 1'b0;
        repeat (4) step();
        frames++;
        sample(3'd1, 1'b1, IRQ_ON, "irq_set_wins");
        wb_wr(8'h14, 8'h01);
        sample(3'd1, 1'b1, 1'b0, "irq_cleared");
        wb_rd(8'h14, 8'h02, "status_after_clear");
        wb_rd(8'h10, IRQ_ON ? 8'h07 : 8'h03, "ctrl_irq_bit");
        wb_rd(8'h15, 8'(frames), "fcnt_final");

        repeat (4) step();
        n_test++;
        if ((bus_q.size() != 0) || (out_q.size() != 0)) begin
            n_fail++;
            $display("FAIL queues_drained: bus=%0d out=%0d left, required 0 and 0", bus_q.size(), out_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
